// File: rtl/keypad_if.sv
// Producer/consumer bundle between the 4x4 keypad scanner, the keypad matrix and the lock logic.
// master = scanner side, slave = keypad matrix / code consumer side.
interface keypad_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] button;
  logic       bstate;

  modport master (input col, output row, button, bstate);
  modport slave  (output col, input row, button, bstate);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe, debounces the synchronized
// columns at one sample per row dwell, and presents each accepted press as button/bstate.
module keypad_scanner #(
  parameter int SCAN_DIV     = 12000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic     hwclk,
  input  logic     rst_n,
  keypad_if.master kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBC_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DBC_W-1:0] DBC_DONE = DBC_W'(DEBOUNCE_CNT);
  localparam logic [DBC_W-1:0] DBC_ONE  = DBC_W'(1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_e;

  logic [3:0]       col_meta_q, col_s_q;
  logic [DIV_W-1:0] div_q, div_d;
  state_e           state_q, state_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       button_q, button_d;
  logic [DBC_W-1:0] dbc_q, dbc_d, dbc_inc;
  logic             bstate_q, bstate_d;
  logic             sample, key_seen, advance;
  logic [1:0]       col_idx;
  logic [3:0]       code;

  assign sample   = (div_q == DIV_LAST);
  assign div_d    = sample ? '0 : div_q + 1'b1;
  assign key_seen = (col_s_q != 4'b1111);
  assign code     = {row_idx_q, col_idx};
  assign dbc_inc  = dbc_q + 1'b1;

  // Lowest-numbered low column wins when several keys in the strobed row are down.
  always_comb begin
    col_idx = 2'd3;
    if      (!col_s_q[0]) col_idx = 2'd0;
    else if (!col_s_q[1]) col_idx = 2'd1;
    else if (!col_s_q[2]) col_idx = 2'd2;
  end

  // NOTE: every always_comb output gets a default before the case so no path leaves it
  // unassigned; a missing default silently infers a latch.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    dbc_d    = dbc_q;
    button_d = button_q;
    bstate_d = bstate_q;
    advance  = 1'b0;
    unique case (state_q)
      ST_SCAN: begin
        if (sample) begin
          if (key_seen) begin
            cand_d  = code;
            dbc_d   = DBC_ONE;
            state_d = ST_DEBOUNCE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (sample) begin
          if (key_seen && (code == cand_q)) begin
            dbc_d = dbc_inc;
            if (dbc_inc >= DBC_DONE) begin
              button_d = cand_q;
              state_d  = ST_PRESSED;
            end
          end else begin
            state_d = ST_SCAN;
            advance = 1'b1;
          end
        end
      end
      ST_PRESSED: begin
        // bstate trails the button update by one cycle so the code is settled first.
        bstate_d = 1'b1;
        if (sample && !key_seen) begin
          dbc_d   = DBC_ONE;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (sample) begin
          if (!key_seen) begin
            dbc_d = dbc_inc;
            if (dbc_inc >= DBC_DONE) begin
              bstate_d = 1'b0;
              state_d  = ST_SCAN;
              advance  = 1'b1;
            end
          end else begin
            dbc_d   = '0;
            state_d = ST_PRESSED;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  assign row_idx_d = advance ? row_idx_q + 2'd1 : row_idx_q;
  assign row_d     = advance ? {row_q[2:0], row_q[3]} : row_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'b1111;
      col_s_q    <= 4'b1111;
      div_q      <= '0;
      state_q    <= ST_SCAN;
      row_idx_q  <= 2'd0;
      row_q      <= 4'b1110;
      cand_q     <= 4'd0;
      button_q   <= 4'd0;
      dbc_q      <= '0;
      bstate_q   <= 1'b0;
    end else begin
      col_meta_q <= kp.col;
      col_s_q    <= col_meta_q;
      div_q      <= div_d;
      state_q    <= state_d;
      row_idx_q  <= row_idx_d;
      row_q      <= row_d;
      cand_q     <= cand_d;
      button_q   <= button_d;
      dbc_q      <= dbc_d;
      bstate_q   <= bstate_d;
    end
  end

  assign kp.row    = row_q;
  assign kp.button = button_q;
  assign kp.bstate = bstate_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad and a press scoreboard
// that is checked on every falling edge of bstate.
module tb_keypad_scanner;

  logic        hwclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys  = '0;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  int pops   = 0;
  logic [3:0] sb[$];
  logic       bstate_prev = 1'b0;

  keypad_if kp ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .kp    (kp.master)
  );

  always #5 hwclk = ~hwclk;

  // Key (r,c) pulls column c low while row r is strobed low.
  always_comb begin
    kp.col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !kp.row[r]) kp.col[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Consumer model: a completed press is the falling edge of bstate outside reset.
  always @(negedge hwclk) begin
    if (rst_n) begin
      if (kp.bstate && !bstate_prev) rises++;
      if (!kp.bstate && bstate_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected_press: observed button %0d expected no press", kp.button);
        end else begin
          check("sb_button", kp.button, sb.pop_front());
          pops++;
        end
      end
    end
    bstate_prev = kp.bstate;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic wait_bstate(input logic val, input int budget, input string tag);
    int n = 0;
    while (kp.bstate !== val && n < budget) begin
      @(negedge hwclk);
      n++;
    end
    check(tag, kp.bstate, val);
  endtask

  task automatic wait_button(input logic [3:0] val, input int budget, input string tag);
    int n = 0;
    while (kp.button !== val && n < budget) begin
      @(negedge hwclk);
      n++;
    end
    check(tag, kp.button, val);
  endtask

  initial begin
    int n;
    int r0;
    int low_cnt;
    logic [3:0] prev_row;

    // 1. Reset state and free-running row scan.
    tick(2);
    check("rst_row", kp.row, 4'b1110);
    check("rst_button", kp.button, 4'd0);
    check("rst_bstate", kp.bstate, 1'b0);
    rst_n = 1'b1;
    tick(3);  check("scan_row_k3", kp.row, 4'b1110);
    tick(1);  check("scan_row_k4", kp.row, 4'b1101);
    tick(4);  check("scan_row_k8", kp.row, 4'b1011);
    tick(4);  check("scan_row_k12", kp.row, 4'b0111);
    tick(4);  check("scan_row_k16", kp.row, 4'b1110);

    // 2. Clean press of row2/col1, then release latency.
    keys[9] = 1'b1;
    sb.push_back(4'd9);
    wait_button(4'd9, 100, "t2_button");
    check("t2_bstate_lags_button", kp.bstate, 1'b0);
    tick(1);
    check("t2_bstate_rise", kp.bstate, 1'b1);
    tick(40);
    check("t2_held_bstate", kp.bstate, 1'b1);
    keys[9] = 1'b0;
    n = 0;
    while (kp.bstate === 1'b1 && n < 40) begin
      @(posedge hwclk); #1;
      n++;
    end
    check("t2_release_latency_in_11_14", (n >= 11 && n <= 14), 1'b1);
    tick(1);
    check("t2_button_holds", kp.button, 4'd9);

    // 3. Bouncy press on row0/col1 gives exactly one pulse.
    r0 = rises;
    sb.push_back(4'd1);
    keys[1] = 1'b1; tick(4);
    keys[1] = 1'b0; tick(4);
    keys[1] = 1'b1; tick(4);
    keys[1] = 1'b0; tick(4);
    keys[1] = 1'b1;
    wait_bstate(1'b1, 100, "t3_bstate_rise");
    check("t3_button", kp.button, 4'd1);
    tick(20);
    keys[1] = 1'b0;
    wait_bstate(1'b0, 60, "t3_bstate_fall");
    tick(2);
    check("t3_one_pulse", rises - r0, 1);

    // 4. Two-sample glitch on row0/col3: row freezes, then scan resumes.
    r0 = rises;
    n = 0;
    prev_row = kp.row;
    while (!(kp.row === 4'b1110 && prev_row === 4'b0111) && n < 40) begin
      prev_row = kp.row;
      @(negedge hwclk);
      n++;
    end
    check("t4_align_row0", kp.row, 4'b1110);
    keys[3] = 1'b1;
    tick(8);
    check("t4_row_frozen", kp.row, 4'b1110);
    keys[3] = 1'b0;
    tick(4);
    check("t4_row_advances", kp.row, 4'b1101);
    check("t4_no_bstate", rises - r0, 0);
    check("t4_button_unchanged", kp.button, 4'd1);

    // 5. Two keys in row1 resolve to the lower column; release bounce keeps bstate high.
    r0 = rises;
    keys[4] = 1'b1;
    keys[6] = 1'b1;
    sb.push_back(4'd4);
    wait_button(4'd4, 100, "t5_button");
    wait_bstate(1'b1, 4, "t5_bstate_rise");
    tick(12);
    low_cnt = 0;
    keys[4] = 1'b0;
    keys[6] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (kp.bstate !== 1'b1) low_cnt++;
    end
    keys[4] = 1'b1;
    keys[6] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (kp.bstate !== 1'b1) low_cnt++;
    end
    check("t5_bounce_bstate_held", low_cnt, 0);
    keys[4] = 1'b0;
    keys[6] = 1'b0;
    wait_bstate(1'b0, 60, "t5_bstate_fall");
    tick(2);
    check("t5_one_pulse", rises - r0, 1);

    // 6. Reset while a key is held, then a fresh debounced press.
    keys[13] = 1'b1;
    sb.push_back(4'd13);
    wait_bstate(1'b1, 100, "t6_bstate_rise");
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_bstate", kp.bstate, 1'b0);
    check("t6_rst_button", kp.button, 4'd0);
    check("t6_rst_row", kp.row, 4'b1110);
    sb.delete();
    tick(2);
    rst_n = 1'b1;
    tick(8);
    check("t6_no_early_bstate", kp.bstate, 1'b0);
    sb.push_back(4'd13);
    wait_bstate(1'b1, 100, "t6_rerise");
    check("t6_button", kp.button, 4'd13);
    keys[13] = 1'b0;
    wait_bstate(1'b0, 60, "t6_bstate_fall");
    tick(2);
    check("sb_drained", sb.size(), 0);
    check("sb_press_count", pops, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
